// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the data_memory bus between the CPU (m0) and a DMA/config engine (m1).
// Optional feature: define ARB_TIMER_PROTECT_EN to reject m1 writes to the timer registers (addresses 0-3).
module mem_bus_arbiter #(
    parameter int unsigned ADDR_MAX   = 100,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [DATA_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [DATA_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  mem_read,
    output logic                  mem_write
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state;
    logic                  gnt_id;
    logic                  last_gnt;
    logic                  lat_we;
    logic                  err_flag;

    logic                  pick_m1;
    logic                  sel_we;
    logic                  sel_protect;
    logic                  sel_reject;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Grant decision and legality check are made on the live request so the
    // strobes can be registered straight into the ACCESS cycle.
    always_comb begin
        pick_m1   = m1_req && (!m0_req || !last_gnt);
        sel_we    = pick_m1 ? m1_we    : m0_we;
        sel_addr  = pick_m1 ? m1_addr  : m0_addr;
        sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
`ifdef ARB_TIMER_PROTECT_EN
        sel_protect = pick_m1 && m1_we && (m1_addr <= DATA_WIDTH'(3));
`else
        sel_protect = 1'b0;
`endif
        sel_reject = (sel_addr > DATA_WIDTH'(ADDR_MAX)) || sel_protect;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt_id    <= 1'b0;
            last_gnt  <= 1'b1;
            lat_we    <= 1'b0;
            err_flag  <= 1'b0;
            address   <= '0;
            data_in   <= '0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt_id    <= pick_m1;
                        lat_we    <= sel_we;
                        address   <= sel_addr;
                        data_in   <= sel_wdata;
                        err_flag  <= sel_reject;
                        mem_read  <= !sel_reject && !sel_we;
                        mem_write <= !sel_reject && sel_we;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!err_flag && !lat_we) begin
                        rdata <= data_out;
                    end
                    last_gnt <= gnt_id;
                    m0_ack   <= !gnt_id;
                    m1_ack   <= gnt_id;
                    m0_err   <= !gnt_id && err_flag;
                    m1_err   <= gnt_id && err_flag;
                    state    <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_strobe_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(mem_read && mem_write));
    a_strobe_in_access: assert property (@(posedge clk) disable iff (reset)
        (mem_read || mem_write) |-> (state == ACCESS));
    a_ack_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(m0_ack && m1_ack));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of single transactions plus contention and reset sequences.
module tb_mem_bus_arbiter;

`ifdef ARB_TIMER_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] rdata, address, data_in, data_out;
    logic        mem_read, mem_write;

    logic [31:0] mem [0:127] = '{default: '0};

    int n_cmp = 0;
    int n_fail = 0;
    int both_strobe = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_MAX(100), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .rdata(rdata), .address(address), .data_in(data_in), .data_out(data_out),
        .mem_read(mem_read), .mem_write(mem_write)
    );

    // data_memory stand-in: combinational read, write at the end of the strobe cycle
    assign data_out = (address < 32'd128) ? mem[address[6:0]] : '0;
    always @(posedge clk) if (mem_write && address < 32'd128) mem[address[6:0]] <= data_in;
    always @(negedge clk) if (mem_read && mem_write) both_strobe++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          master;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [16];

    int          t_lat, t_wcnt, t_rcnt, t_scyc;
    bit          t_err, t_other, t_ack_after;
    logic [31:0] t_rd, t_rd_after, t_saddr, t_sdata;

    task automatic run_txn(input bit master, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bit done = 1'b0;
        @(posedge clk); #1;
        if (master) begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else        begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        t_lat = 0; t_wcnt = 0; t_rcnt = 0; t_scyc = 0; t_other = 1'b0; t_err = 1'b0;
        t_rd = 'x; t_saddr = 'x; t_sdata = 'x;
        for (int n = 1; n <= 10 && !done; n++) begin
            @(negedge clk);
            if (mem_write) begin t_wcnt++; t_saddr = address; t_sdata = data_in; t_scyc = n; end
            if (mem_read)  begin t_rcnt++; t_saddr = address; t_scyc = n; end
            if (master ? m0_ack : m1_ack) t_other = 1'b1;
            if (master ? m1_ack : m0_ack) begin
                t_lat = n; t_err = master ? m1_err : m0_err; t_rd = rdata; done = 1'b1;
            end
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        t_ack_after = m0_ack | m1_ack;
        t_rd_after  = rdata;
    endtask

    logic [31:0] r5;
    int          c0a, c0b, c1, m0_acks, both_ack, first_n;
    logic [31:0] r0a, r0b, r1;
    bit          a0, a1, any_ack, first_m, have_first;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("reset_outputs_ctl", 32'({m0_ack, m1_ack, m0_err, m1_err, mem_read, mem_write}), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_address", address, 32'h0);
        check("reset_data_in", data_in, 32'h0);
        @(posedge clk); #1; reset = 1'b0;

        r5 = PROT ? 32'h0 : 32'h0000_000A;
        vecs[0]  = '{1'b0, 1'b1, 32'd10,         32'h0000_00A5, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'd50,         32'h0000_1234, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'd50,         32'h0,         1'b0, 32'h0000_1234};
        vecs[3]  = '{1'b1, 1'b0, 32'd101,        32'h0,         1'b1, 32'h0000_1234};
        vecs[4]  = '{1'b1, 1'b1, 32'd0,          32'h0000_000A, PROT, 32'h0000_1234};
        vecs[5]  = '{1'b1, 1'b0, 32'd0,          32'h0,         1'b0, r5};
        vecs[6]  = '{1'b1, 1'b1, 32'd100,        32'hDEAD_BEEF, 1'b0, r5};
        vecs[7]  = '{1'b0, 1'b0, 32'd100,        32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'h0000_0001, 1'b1, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 1'b0, 32'd10,         32'h0,         1'b0, 32'h0000_00A5};
        vecs[10] = '{1'b0, 1'b1, 32'd3,          32'h0000_0077, 1'b0, 32'h0000_00A5};
        vecs[11] = '{1'b1, 1'b0, 32'd3,          32'h0,         1'b0, 32'h0000_0077};
        vecs[12] = '{1'b0, 1'b1, 32'd20,         32'h0000_2020, 1'b0, 32'h0000_0077};
        vecs[13] = '{1'b1, 1'b1, 32'd21,         32'h0000_2121, 1'b0, 32'h0000_0077};
        vecs[14] = '{1'b0, 1'b1, 32'd22,         32'h0000_2222, 1'b0, 32'h0000_0077};
        vecs[15] = '{1'b1, 1'b0, 32'd22,         32'h0,         1'b0, 32'h0000_2222};

        for (int i = 0; i < 16; i++) begin
            run_txn(vecs[i].master, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d latency", i), 32'(t_lat), 32'd3);
            check($sformatf("v%0d err", i), 32'(t_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d write_cycles", i), 32'(t_wcnt), 32'(vecs[i].we && !vecs[i].exp_err));
            check($sformatf("v%0d read_cycles", i), 32'(t_rcnt), 32'(!vecs[i].we && !vecs[i].exp_err));
            if (!vecs[i].exp_err) begin
                check($sformatf("v%0d strobe_cycle", i), 32'(t_scyc), 32'd2);
                check($sformatf("v%0d bus_address", i), t_saddr, vecs[i].addr);
                if (vecs[i].we) check($sformatf("v%0d bus_data_in", i), t_sdata, vecs[i].wdata);
            end
            check($sformatf("v%0d rdata", i), t_rd, vecs[i].exp_rdata);
            check($sformatf("v%0d rdata_hold", i), t_rd_after, vecs[i].exp_rdata);
            check($sformatf("v%0d ack_one_cycle", i), 32'(t_ack_after), 32'd0);
            check($sformatf("v%0d other_ack", i), 32'(t_other), 32'd0);
        end

        // contention: m0 wins, re-requests while held, then m1 must win the next contention
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd21;
        c0a = 0; c0b = 0; c1 = 0; m0_acks = 0; both_ack = 0;
        r0a = 'x; r0b = 'x; r1 = 'x;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            a0 = m0_ack; a1 = m1_ack;
            if (a0 && a1) both_ack++;
            if (a0) begin
                if (m0_acks == 0) begin c0a = n; r0a = rdata; end
                else begin c0b = n; r0b = rdata; end
                m0_acks++;
            end
            if (a1) begin c1 = n; r1 = rdata; end
            @(posedge clk); #1;
            if (a0 && m0_acks == 1) m0_addr = 32'd22;
            if (a0 && m0_acks == 2) m0_req = 1'b0;
            if (a1) m1_req = 1'b0;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("cont m0_first_ack_cycle", 32'(c0a), 32'd3);
        check("cont m0_first_rdata", r0a, 32'h0000_2020);
        check("cont m1_ack_cycle", 32'(c1), 32'd6);
        check("cont m1_rdata", r1, 32'h0000_2121);
        check("cont m0_second_ack_cycle", 32'(c0b), 32'd9);
        check("cont m0_second_rdata", r0b, 32'h0000_2222);
        check("cont both_ack", 32'(both_ack), 32'd0);

        // reset asserted mid-ACCESS of an m0 write
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd60; m0_wdata = 32'h0000_0055;
        @(posedge clk); #2;
        check("rst pre_mem_write", 32'(mem_write), 32'd1);
        #1; reset = 1'b1;
        #1;
        check("rst async_mem_write", 32'(mem_write), 32'd0);
        check("rst outputs_zero", 32'(|{m0_ack, m1_ack, m0_err, m1_err, rdata, address, data_in, mem_read, mem_write}), 32'd0);
        m0_req = 1'b0;
        any_ack = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            any_ack = any_ack | m0_ack | m1_ack;
        end
        @(posedge clk); #1; reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            any_ack = any_ack | m0_ack | m1_ack;
        end
        check("rst no_ack", 32'(any_ack), 32'd0);
        check("rst write_aborted", mem[60], 32'h0);

        // after reset m0 must win the first contention again
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd21;
        have_first = 1'b0; first_m = 1'b1; first_n = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            a0 = m0_ack; a1 = m1_ack;
            if (!have_first && (a0 || a1)) begin have_first = 1'b1; first_m = a1; first_n = n; end
            @(posedge clk); #1;
            if (a0) m0_req = 1'b0;
            if (a1) m1_req = 1'b0;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("post_rst first_grant_m1", 32'(first_m), 32'd0);
        check("post_rst first_ack_cycle", 32'(first_n), 32'd3);
        check("strobes_never_both", 32'(both_strobe), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
